// File: rtl/uart_pkg.sv
// Shared types and defaults for the UART receive path: state encoding,
// default frame geometry and the mid-bit / majority helpers.
package uart_pkg;

  localparam int unsigned DATA_BITS_DEF   = 8;
  localparam int unsigned OVERSAMPLE_DEF  = 16;
  localparam int unsigned SYNC_STAGES_DEF = 2;

  typedef enum logic [1:0] {
    RX_IDLE  = 2'd0,
    RX_START = 2'd1,
    RX_DATA  = 2'd2,
    RX_STOP  = 2'd3
  } rx_state_e;

  // Sample index at which the start bit is re-checked (half a bit in).
  function automatic int unsigned mid_bit(input int unsigned oversample);
    return oversample / 2 - 1;
  endfunction

  localparam int unsigned MID_BIT_DEF = OVERSAMPLE_DEF / 2 - 1;

  function automatic logic maj3(input logic [2:0] v);
    return (v[0] & v[1]) | (v[0] & v[2]) | (v[1] & v[2]);
  endfunction

endpackage

// File: rtl/uart_rx_sync.sv
// Multi-flop synchroniser for an asynchronous level input; flops reset high
// so an idle-high line does not look like activity coming out of reset.
module uart_rx_sync
  import uart_pkg::*;
#(
  parameter int unsigned STAGES = SYNC_STAGES_DEF
) (
  input  logic clk_50m,
  input  logic rst_n,
  input  logic d_i,
  output logic q_o
);

  logic [STAGES-1:0] sync_q;

  generate
    if (STAGES == 1) begin : g_one
      always_ff @(posedge clk_50m or negedge rst_n) begin
        if (!rst_n) begin
          sync_q <= '1;
        end else begin
          sync_q <= d_i;
        end
      end
    end else begin : g_chain
      always_ff @(posedge clk_50m or negedge rst_n) begin
        if (!rst_n) begin
          sync_q <= '1;
        end else begin
          sync_q <= {sync_q[STAGES-2:0], d_i};
        end
      end
    end
  endgenerate

  assign q_o = sync_q[STAGES-1];

endmodule

// File: rtl/uart_rx.sv
// 8N1 UART receiver driven by a 16x oversample enable. Optional 2-of-3
// majority voting on every mid-bit decision is enabled by UART_RX_MAJORITY_EN.
module uart_rx
  import uart_pkg::*;
#(
  parameter int unsigned DATA_BITS   = DATA_BITS_DEF,
  parameter int unsigned OVERSAMPLE  = OVERSAMPLE_DEF,
  parameter int unsigned SYNC_STAGES = SYNC_STAGES_DEF
) (
  input  logic                 clk_50m,
  input  logic                 rst_n,
  input  logic                 rxclk_en,
  input  logic                 rx,
  input  logic                 rdy_clr,
  output logic                 rdy,
  output logic [DATA_BITS-1:0] dout,
  output logic                 frame_err,
  output logic                 overrun,
  output logic                 busy
);

  localparam int unsigned SW = $clog2(OVERSAMPLE);
  localparam int unsigned BW = (DATA_BITS > 1) ? $clog2(DATA_BITS) : 1;

  localparam logic [SW-1:0] SAMPLE_MID  = SW'(mid_bit(OVERSAMPLE));
  localparam logic [SW-1:0] SAMPLE_LAST = SW'(OVERSAMPLE - 1);
  localparam logic [BW-1:0] BIT_LAST    = BW'(DATA_BITS - 1);

  logic rx_s;
  logic dec_bit;

  uart_rx_sync #(
    .STAGES (SYNC_STAGES)
  ) u_sync (
    .clk_50m (clk_50m),
    .rst_n   (rst_n),
    .d_i     (rx),
    .q_o     (rx_s)
  );

`ifdef UART_RX_MAJORITY_EN
  // Two previous tick samples plus the current one form the voting window.
  logic [1:0] hist_q;

  always_ff @(posedge clk_50m or negedge rst_n) begin
    if (!rst_n) begin
      hist_q <= 2'b11;
    end else if (rxclk_en) begin
      hist_q <= {hist_q[0], rx_s};
    end
  end

  assign dec_bit = maj3({hist_q, rx_s});
`else
  assign dec_bit = rx_s;
`endif

  rx_state_e            state_q;
  logic [SW-1:0]        sample_q;
  logic [BW-1:0]        bit_q;
  logic [DATA_BITS-1:0] shift_q;
  logic [DATA_BITS-1:0] dout_q;
  logic                 rdy_q;
  logic                 frame_err_q;
  logic                 overrun_q;

  always_ff @(posedge clk_50m or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= RX_IDLE;
      sample_q    <= '0;
      bit_q       <= '0;
      shift_q     <= '0;
      dout_q      <= '0;
      rdy_q       <= 1'b0;
      frame_err_q <= 1'b0;
      overrun_q   <= 1'b0;
    end else begin
      if (rdy_clr) begin
        rdy_q     <= 1'b0;
        overrun_q <= 1'b0;
      end

      if (rxclk_en) begin
        case (state_q)
          RX_IDLE: begin
            if (!rx_s) begin
              state_q  <= RX_START;
              sample_q <= '0;
            end
          end

          RX_START: begin
            if (sample_q == SAMPLE_MID) begin
              sample_q <= '0;
              bit_q    <= '0;
              // A start bit that is high again by mid-bit was a glitch.
              state_q  <= dec_bit ? RX_IDLE : RX_DATA;
            end else begin
              sample_q <= sample_q + 1'b1;
            end
          end

          RX_DATA: begin
            sample_q <= sample_q + 1'b1;
            if (sample_q == SAMPLE_LAST) begin
              shift_q[bit_q] <= dec_bit;
              bit_q          <= bit_q + 1'b1;
              if (bit_q == BIT_LAST) begin
                state_q <= RX_STOP;
              end
            end
          end

          RX_STOP: begin
            sample_q <= sample_q + 1'b1;
            if (sample_q == SAMPLE_LAST) begin
              state_q <= RX_IDLE;
              if (dec_bit) begin
                // A completion overrides a same-cycle clear.
                dout_q      <= shift_q;
                rdy_q       <= 1'b1;
                frame_err_q <= 1'b0;
                overrun_q   <= rdy_q & ~rdy_clr;
              end else begin
                frame_err_q <= 1'b1;
              end
            end
          end

          default: begin
            state_q <= RX_IDLE;
          end
        endcase
      end
    end
  end

  assign rdy       = rdy_q;
  assign dout      = dout_q;
  assign frame_err = frame_err_q;
  assign overrun   = overrun_q;
  assign busy      = (state_q != RX_IDLE);

endmodule

// File: tb/tb_uart_rx.sv
// Self-checking bench for uart_rx: directed frames from the test plan followed
// by randomized frames, compared against a frame-level reference model.
`timescale 1ns/1ps
module tb_uart_rx;

  localparam int DB        = 8;
  localparam int OS        = 16;
  localparam int FRAME_LEN = (DB + 2) * OS;         // ticks per frame on the line
  localparam int STOP_T    = (DB + 1) * OS + OS / 2; // drive index seen at the stop decision

  logic          clk_50m  = 1'b0;
  logic          rst_n    = 1'b0;
  logic          rxclk_en = 1'b0;
  logic          rx       = 1'b1;
  logic          rdy_clr  = 1'b0;
  logic          rdy;
  logic [DB-1:0] dout;
  logic          frame_err;
  logic          overrun;
  logic          busy;

  int checks   = 0;
  int failures = 0;

  logic          exp_rdy  = 1'b0;
  logic          exp_fe   = 1'b0;
  logic          exp_ov   = 1'b0;
  logic [DB-1:0] exp_dout = '0;

  uart_rx #(
    .DATA_BITS   (DB),
    .OVERSAMPLE  (OS),
    .SYNC_STAGES (2)
  ) dut (
    .clk_50m   (clk_50m),
    .rst_n     (rst_n),
    .rxclk_en  (rxclk_en),
    .rx        (rx),
    .rdy_clr   (rdy_clr),
    .rdy       (rdy),
    .dout      (dout),
    .frame_err (frame_err),
    .overrun   (overrun),
    .busy      (busy)
  );

  always #10 clk_50m = ~clk_50m;

  // One enable pulse every 4 clocks.
  initial begin
    forever begin
      repeat (3) @(posedge clk_50m);
      #1 rxclk_en = 1'b1;
      @(posedge clk_50m);
      #1 rxclk_en = 1'b0;
    end
  end

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end else begin
      $display("ok   %s got=%0h", tag, got);
    end
  endtask

  task automatic check_outputs(input string tag);
    check_eq({tag, "_rdy"},  32'(rdy),       32'(exp_rdy));
    check_eq({tag, "_dout"}, 32'(dout),      32'(exp_dout));
    check_eq({tag, "_ferr"}, 32'(frame_err), 32'(exp_fe));
    check_eq({tag, "_ovr"},  32'(overrun),   32'(exp_ov));
  endtask

  // Returns 2 ns after the next clock edge that sampled rxclk_en high.
  task automatic wait_tick();
    do @(posedge clk_50m); while (rxclk_en !== 1'b1);
    #2;
  endtask

  task automatic idle_ticks(input int n);
    rx = 1'b1;
    repeat (n) wait_tick();
  endtask

  // Frame-level reference: what a received stop bit does to the flags.
  task automatic model_frame(input logic [DB-1:0] seen, input logic stop, input logic clr);
    if (stop) begin
      exp_ov   = exp_rdy & ~clr;
      exp_rdy  = 1'b1;
      exp_dout = seen;
      exp_fe   = 1'b0;
    end else begin
      exp_fe = 1'b1;
      if (clr) begin
        exp_rdy = 1'b0;
        exp_ov  = 1'b0;
      end
    end
  endtask

  function automatic logic line_level(input logic [DB-1:0] data, input logic stop, input int t);
    if (t < OS) return 1'b0;
    if (t < (DB + 1) * OS) return data[(t - OS) / OS];
    return stop;
  endfunction

  task automatic pulse_clr();
    rdy_clr = 1'b1;
    @(posedge clk_50m);
    #2 rdy_clr = 1'b0;
    exp_rdy = 1'b0;
    exp_ov  = 1'b0;
    check_eq("clr_rdy", 32'(rdy),     32'(exp_rdy));
    check_eq("clr_ovr", 32'(overrun), 32'(exp_ov));
    wait_tick();
  endtask

  // Drives one frame, one line level per tick. Entry and exit are just after a tick.
  task automatic send_frame(input logic [DB-1:0] data, input logic stop, input int glitch_t,
                            input logic clr_at_stop, input int reset_t, input logic [DB-1:0] seen);
    logic p_rdy;
    logic p_fe;
    p_rdy = exp_rdy;
    p_fe  = exp_fe;
    for (int t = 0; t < FRAME_LEN; t++) begin
      rx = (t == glitch_t) ? 1'b1 : line_level(data, stop, t);
      if (t == reset_t) begin
        check_eq("pre_reset_busy", 32'(busy), 32'd1);
        #3 rst_n = 1'b0;
        #1;
        exp_rdy = 1'b0; exp_fe = 1'b0; exp_ov = 1'b0; exp_dout = '0;
        check_outputs("async_reset");
        check_eq("async_reset_busy", 32'(busy), 32'd0);
        return;
      end
      if (t == STOP_T) begin
        repeat (3) @(posedge clk_50m);
        #2;
        check_eq("pre_stop_rdy",  32'(rdy),       32'(p_rdy));
        check_eq("pre_stop_ferr", 32'(frame_err), 32'(p_fe));
        check_eq("pre_stop_busy", 32'(busy),      32'd1);
        rdy_clr = clr_at_stop;
      end
      wait_tick();
      if (t == STOP_T) begin
        rdy_clr = 1'b0;
        model_frame(seen, stop, clr_at_stop);
        check_outputs("stop_edge");
        check_eq("stop_edge_busy", 32'(busy), 32'd0);
      end
    end
    // A low stop bit looks like a new start bit, so the receiver restarts.
    check_eq("end_busy", 32'(busy), 32'(!stop));
  endtask

  task automatic frame(input logic [DB-1:0] data, input logic stop);
    send_frame(data, stop, -1, 1'b0, -1, data);
  endtask

  logic [DB-1:0] glitch_exp;
  logic [DB-1:0] rd;
  logic          rs;
  logic          rc;

  initial begin
`ifdef UART_RX_MAJORITY_EN
    glitch_exp = 8'h00;
`else
    glitch_exp = 8'h01;
`endif
    #1;
    check_outputs("reset");
    check_eq("reset_busy", 32'(busy), 32'd0);
    repeat (5) @(posedge clk_50m);
    @(negedge clk_50m) rst_n = 1'b1;
    idle_ticks(4);

    // Basic good frame, with stop-edge timing checked inside send_frame.
    frame(8'h55, 1'b1);
    check_outputs("f55");
    pulse_clr();

    // Short low pulse: start bit rejected at the mid-bit check.
    for (int t = 0; t < 12; t++) begin
      rx = (t < 4) ? 1'b0 : 1'b1;
      if (t == 8) check_eq("abort_busy_before", 32'(busy), 32'd1);
      if (t == 9) check_eq("abort_busy_after",  32'(busy), 32'd0);
      wait_tick();
    end
    check_outputs("abort");

    // Framing error keeps dout, then a good frame clears frame_err.
    frame(8'hA3, 1'b0);
    check_outputs("fA3_bad_stop");
    idle_ticks(24);
    check_eq("fA3_idle_busy", 32'(busy), 32'd0);
    frame(8'h3C, 1'b1);
    check_outputs("f3C");

    // Overrun, clear, then clear coincident with completion.
    pulse_clr();
    frame(8'h12, 1'b1);
    frame(8'h34, 1'b1);
    check_outputs("overrun");
    pulse_clr();
    frame(8'h77, 1'b1);
    send_frame(8'h56, 1'b1, -1, 1'b1, -1, 8'h56);
    check_outputs("clr_coincident");
    pulse_clr();

    // One-tick high glitch on bit 0, landing on its decision tick.
    send_frame(8'h00, 1'b1, OS + OS / 2, 1'b0, -1, glitch_exp);
    check_outputs("glitch_bit0");

    // Line held low: one framing error, then an immediate restart.
    frame(8'h00, 1'b0);
    check_outputs("break");
    idle_ticks(24);
    check_eq("break_idle_busy", 32'(busy), 32'd0);

    for (int n = 0; n < 24; n++) begin
      rd = 8'($urandom);
      rs = ($urandom_range(0, 4) != 0);
      rc = ($urandom_range(0, 3) == 0);
      send_frame(rd, rs, -1, rc, -1, rd);
      check_outputs("rnd");
      if (!rs) begin
        idle_ticks(24);
      end else begin
        case ($urandom_range(0, 2))
          0: ;
          1: idle_ticks(int'($urandom_range(1, 5)));
          default: begin
            pulse_clr();
            idle_ticks(1);
          end
        endcase
      end
    end

    // Reset mid-DATA, then recover with a good frame.
    frame(8'hC9, 1'b1);
    send_frame(8'hAA, 1'b1, -1, 1'b0, 3 * OS + 4, 8'hAA);
    rx = 1'b1;
    repeat (3) @(posedge clk_50m);
    @(negedge clk_50m) rst_n = 1'b1;
    idle_ticks(4);
    check_outputs("post_reset");
    frame(8'hF0, 1'b1);
    check_outputs("fF0");

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
